// File: rtl/present_inv_keyadd_sbox_serial.sv
// Serial inverse PRESENT S-box/key-add over a 12-bit word. Each nibble is evaluated
// twice through one shared inverse S-box and compared, so transient faults are flagged.
module present_inv_keyadd_sbox_serial #(
   parameter int NIBBLES = 3
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   io_in_valid,
   output logic                   io_in_ready,
   input  logic [4*NIBBLES-1:0]   io_in,
   input  logic [4*NIBBLES-1:0]   io_key,
   output logic                   io_out_valid,
   input  logic                   io_out_ready,
   output logic [4*NIBBLES-1:0]   io_out,
   output logic                   io_fault
);
   localparam int         W        = 4 * NIBBLES;
   localparam logic [1:0] LAST_IDX = 2'(NIBBLES - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CALC  = 2'd1;
   localparam logic [1:0] ST_CHECK = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]   state_reg, state_next;
   logic [1:0]   idx_reg, idx_next;
   logic [W-1:0] data_reg, data_next;
   logic [W-1:0] key_reg, key_next;
   logic [W-1:0] result_reg, result_next;
   logic [W-1:0] out_reg, out_next;
   logic [3:0]   temp_reg, temp_next;
   logic         fault_reg, fault_next;

   logic [3:0]   sbox_in;
   logic [3:0]   sbox_out;
   logic [W-1:0] result_wr;
   logic         clear_all;

   function automatic logic [3:0] inv_sbox(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'h5;
         4'h1: y = 4'hE;
         4'h2: y = 4'hF;
         4'h3: y = 4'h8;
         4'h4: y = 4'hC;
         4'h5: y = 4'h1;
         4'h6: y = 4'h2;
         4'h7: y = 4'hD;
         4'h8: y = 4'hB;
         4'h9: y = 4'h4;
         4'hA: y = 4'h6;
         4'hB: y = 4'h3;
         4'hC: y = 4'h0;
         4'hD: y = 4'h7;
         4'hE: y = 4'h9;
         default: y = 4'hA;
      endcase
      return y;
   endfunction

   // Single shared S-box: both the CALC and the CHECK pass read this same path.
   always_comb begin
      sbox_in = 4'h0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx_reg == 2'(i)) sbox_in = data_reg[4*i +: 4] ^ key_reg[4*i +: 4];
      end
   end

   assign sbox_out = inv_sbox(sbox_in);

   generate
      for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
         assign result_wr[4*gi +: 4] = (idx_reg == 2'(gi)) ? temp_reg : result_reg[4*gi +: 4];
      end
   endgenerate

   always_comb begin
      state_next  = state_reg;
      idx_next    = idx_reg;
      data_next   = data_reg;
      key_next    = key_reg;
      result_next = result_reg;
      out_next    = out_reg;
      temp_next   = temp_reg;
      fault_next  = fault_reg;
      clear_all   = (idx_reg > LAST_IDX);

      case (state_reg)
         ST_IDLE: begin
            if (io_in_valid) begin
               data_next   = io_in;
               key_next    = io_key;
               idx_next    = 2'd0;
               result_next = '0;
               temp_next   = 4'h0;
               fault_next  = 1'b0;
               state_next  = ST_CALC;
            end
         end
         ST_CALC: begin
            temp_next  = sbox_out;
            state_next = ST_CHECK;
         end
         ST_CHECK: begin
            if (sbox_out == temp_reg) begin
               result_next = result_wr;
               if (idx_reg == LAST_IDX) begin
                  out_next   = result_wr;
                  state_next = ST_DONE;
               end else begin
                  idx_next   = idx_reg + 2'd1;
                  state_next = ST_CALC;
               end
            end else begin
               // Mismatch: suppress the whole word and skip the remaining nibbles.
               fault_next = 1'b1;
               out_next   = '0;
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (io_out_ready) begin
               data_next  = '0;
               key_next   = '0;
               out_next   = '0;
               fault_next = 1'b0;
               state_next = ST_IDLE;
            end
         end
         default: clear_all = 1'b1;
      endcase

      if (clear_all) begin
         state_next  = ST_IDLE;
         idx_next    = 2'd0;
         data_next   = '0;
         key_next    = '0;
         result_next = '0;
         out_next    = '0;
         temp_next   = 4'h0;
         fault_next  = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg  <= ST_IDLE;
         idx_reg    <= 2'd0;
         data_reg   <= '0;
         key_reg    <= '0;
         result_reg <= '0;
         out_reg    <= '0;
         temp_reg   <= 4'h0;
         fault_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         idx_reg    <= idx_next;
         data_reg   <= data_next;
         key_reg    <= key_next;
         result_reg <= result_next;
         out_reg    <= out_next;
         temp_reg   <= temp_next;
         fault_reg  <= fault_next;
      end
   end

   assign io_in_ready  = (state_reg == ST_IDLE);
   assign io_out_valid = (state_reg == ST_DONE);
   assign io_out       = out_reg;
   assign io_fault     = fault_reg;

endmodule

// File: tb/tb_present_inv_keyadd_sbox_serial.sv
// Self-checking bench for present_inv_keyadd_sbox_serial: vector table, scoreboard queue,
// and hand-written sequences for backpressure, fault injection and reset.
module tb_present_inv_keyadd_sbox_serial;
   logic        clock = 1'b0;
   logic        reset;
   logic        io_in_valid;
   logic        io_in_ready;
   logic [11:0] io_in;
   logic [11:0] io_key;
   logic        io_out_valid;
   logic        io_out_ready;
   logic [11:0] io_out;
   logic        io_fault;

   typedef struct {
      logic [11:0] din;
      logic [11:0] key;
      logic [11:0] exp_out;
      logic        exp_fault;
   } vec_t;

   typedef struct {
      logic [11:0] out;
      logic        fault;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        exp_q[$];
   vec_t        vecs[17];
   int          pass_cnt = 0;
   int          total_cnt = 0;
   int          cyc = 0;
   int          last_acc = 0;
   int          txn = 0;
   logic [3:0]  force_val;

   present_inv_keyadd_sbox_serial #(.NIBBLES(3)) dut (
      .clock        (clock),
      .reset        (reset),
      .io_in_valid  (io_in_valid),
      .io_in_ready  (io_in_ready),
      .io_in        (io_in),
      .io_key       (io_key),
      .io_out_valid (io_out_valid),
      .io_out_ready (io_out_ready),
      .io_out       (io_out),
      .io_fault     (io_fault)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
      $fatal(1, "watchdog");
   end

   function automatic logic [3:0] inv_s(input logic [3:0] x);
      logic [63:0] t;
      t = 64'hA970364BD21C8FE5;
      return t[4*x +: 4];
   endfunction

   function automatic logic [11:0] model(input logic [11:0] d, input logic [11:0] k);
      logic [11:0] r;
      r = '0;
      for (int i = 0; i < 3; i++) r[4*i +: 4] = inv_s(d[4*i +: 4] ^ k[4*i +: 4]);
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %0h required %0h", name, act, req);
   endtask

   // Present a word and hold valid until the accepting edge; valid is left high.
   task automatic accept(input logic [11:0] din, input logic [11:0] k,
                         input logic [11:0] eo, input logic ef, input int lat);
      exp_t e;
      int   n;
      n = 0;
      io_in = din;
      io_key = k;
      io_in_valid = 1'b1;
      while (!io_in_ready && n < 40) begin
         @(posedge clock); #1;
         n++;
      end
      if (!io_in_ready) begin
         total_cnt++;
         $display("FAIL accept_timeout: io_in_ready got 0 required 1 within 40 cycles");
         return;
      end
      @(posedge clock); #1;
      e.out = eo;
      e.fault = ef;
      e.lat = lat;
      e.acc = cyc;
      exp_q.push_back(e);
      last_acc = cyc;
   endtask

   task automatic wait_valid(input string name, output bit ok);
      int n;
      n = 0;
      while (!io_out_valid && n < 40) begin
         @(posedge clock); #1;
         n++;
      end
      ok = io_out_valid;
      if (!ok) begin
         total_cnt++;
         $display("FAIL %s_valid_timeout: io_out_valid got 0 required 1 within 40 cycles", name);
      end
   endtask

   task automatic wait_result(input string name, input int hold);
      exp_t e;
      bit   ok;
      wait_valid(name, ok);
      if (!ok) return;
      if (exp_q.size() == 0) begin
         total_cnt++;
         $display("FAIL %s_scoreboard: got a result, required an empty output", name);
         return;
      end
      e = exp_q.pop_front();
      txn++;
      $display("txn %0d %s: out=%h fault=%0d latency=%0d", txn, name, io_out, io_fault, cyc - e.acc + 1);
      check({name, "_out"}, 32'(io_out), 32'(e.out));
      check({name, "_fault"}, 32'(io_fault), 32'(e.fault));
      check({name, "_latency"}, cyc - e.acc + 1, e.lat);
      if (hold > 0) begin
         io_out_ready = 1'b0;
         for (int c = 0; c < hold; c++) begin
            io_in_valid = (c == 5);
            io_in = 12'h3C3;
            io_key = 12'h111;
            @(posedge clock); #1;
            check({name, "_hold_out"}, 32'(io_out), 32'(e.out));
            check({name, "_hold_fault"}, 32'(io_fault), 32'(e.fault));
            check({name, "_hold_in_ready"}, 32'(io_in_ready), 32'd0);
            check({name, "_hold_valid"}, 32'(io_out_valid), 32'd1);
         end
         io_in_valid = 1'b0;
         io_out_ready = 1'b1;
      end
      @(posedge clock); #1;
      check({name, "_valid_drop"}, 32'(io_out_valid), 32'd0);
      check({name, "_out_zero"}, 32'(io_out), 32'd0);
      check({name, "_fault_zero"}, 32'(io_fault), 32'd0);
      check({name, "_ready_back"}, 32'(io_in_ready), 32'd1);
   endtask

   initial begin
      logic [11:0] exh_exp [16];
      logic [11:0] din;
      logic [11:0] k;
      logic [3:0]  vn;
      int          prev_acc;
      int          seen;
      bit          ok;

      exh_exp = '{12'h555, 12'hEEE, 12'hFFF, 12'h888, 12'hCCC, 12'h111, 12'h222, 12'hDDD,
                  12'hBBB, 12'h444, 12'h666, 12'h333, 12'h000, 12'h777, 12'h999, 12'hAAA};
      vecs[0] = '{12'hFD7, 12'hABC, 12'h123, 1'b0};
      for (int v = 0; v < 16; v++) begin
         vn = 4'(v);
         vecs[v+1] = '{{vn, vn, vn}, 12'h000, exh_exp[v], 1'b0};
      end

      reset = 1'b0;
      io_in_valid = 1'b0;
      io_in = '0;
      io_key = '0;
      io_out_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      check("rst_in_ready", 32'(io_in_ready), 32'd1);
      check("rst_out_valid", 32'(io_out_valid), 32'd0);
      check("rst_out", 32'(io_out), 32'd0);
      check("rst_fault", 32'(io_fault), 32'd0);
      reset = 1'b1;

      // Round trip plus exhaustive inverse table, valid held high throughout.
      for (int i = 0; i < 17; i++) begin
         accept(vecs[i].din, vecs[i].key, vecs[i].exp_out, vecs[i].exp_fault, 7);
         wait_result($sformatf("vec%0d", i), 0);
      end
      io_in_valid = 1'b0;

      // Backpressure: 20 stalled DONE cycles with a stray valid pulse.
      accept(12'hFD7, 12'hABC, 12'h123, 1'b0, 7);
      io_in_valid = 1'b0;
      wait_result("backpressure", 20);
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clock); #1;
         if (io_out_valid || !io_in_ready) seen++;
      end
      check("bp_pulse_not_captured", seen, 0);

      // Fault injection on nibble 1 during its CHECK cycle.
      din = 12'h5A3;
      k = 12'h0F0;
      force_val = inv_s(din[7:4] ^ k[7:4]) ^ 4'h1;
      accept(din, k, 12'h000, 1'b1, 5);
      io_in_valid = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      force dut.temp_reg = force_val;
      @(posedge clock); #1;
      release dut.temp_reg;
      wait_result("fault_inj", 0);
      accept(din, k, model(din, k), 1'b0, 7);
      io_in_valid = 1'b0;
      wait_result("after_fault", 0);

      // Reset during the second CALC discards the word.
      accept(12'h9E1, 12'h4B2, model(12'h9E1, 12'h4B2), 1'b0, 7);
      io_in_valid = 1'b0;
      repeat (2) @(posedge clock);
      #3;
      reset = 1'b0;
      #1;
      check("rst_mid_valid", 32'(io_out_valid), 32'd0);
      check("rst_mid_fault", 32'(io_fault), 32'd0);
      check("rst_mid_in_ready", 32'(io_in_ready), 32'd1);
      exp_q.delete();
      @(posedge clock); #1;
      reset = 1'b1;
      check("rst_mid_ready_after", 32'(io_in_ready), 32'd1);
      accept(12'h6B0, 12'h2D5, model(12'h6B0, 12'h2D5), 1'b0, 7);
      io_in_valid = 1'b0;
      wait_result("after_rst_mid", 0);

      // Reset while stalled in DONE drops the held result at once.
      accept(12'h0F0, 12'hF0F, model(12'h0F0, 12'hF0F), 1'b0, 7);
      io_in_valid = 1'b0;
      io_out_ready = 1'b0;
      wait_valid("rst_done", ok);
      if (ok) check("rst_done_out_before", 32'(io_out), 32'(model(12'h0F0, 12'hF0F)));
      #2;
      reset = 1'b0;
      #1;
      check("rst_done_valid", 32'(io_out_valid), 32'd0);
      check("rst_done_out", 32'(io_out), 32'd0);
      check("rst_done_fault", 32'(io_fault), 32'd0);
      exp_q.delete();
      @(posedge clock); #1;
      reset = 1'b1;
      io_out_ready = 1'b1;

      // Back-to-back random words with continuous valid.
      prev_acc = 0;
      for (int i = 0; i < 6; i++) begin
         din = 12'($urandom);
         k = 12'($urandom);
         accept(din, k, model(din, k), 1'b0, 7);
         if (i > 0) check($sformatf("b2b%0d_interval", i), last_acc - prev_acc, 8);
         prev_acc = last_acc;
         wait_result($sformatf("b2b%0d", i), 0);
      end
      io_in_valid = 1'b0;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/present_inv_keyadd_sbox_serial.md
# present_inv_keyadd_sbox_serial

Inverse counterpart of the 3-nibble PRESENT S-box/key-add layer: recovers `state = S⁻¹(in ^ key)` per nibble for 12-bit words. It serves the decryption-side datapath of the fault-vulnerability case study. One shared inverse S-box is time-multiplexed over the three nibbles. Each nibble is computed twice in consecutive cycles and compared, so that transient faults are detected rather than propagated. Operands enter and results leave through valid/ready handshakes.

## Interface
- `NIBBLES`, 3: number of 4-bit nibbles per word; fixed at 3 in this release.
- `clock`  in  1  sole clock; all registers on rising edge.
- `reset`  in  1  asynchronous, active-low; `reset`=0 clears all state immediately.
- `io_in_valid`  in  1  operand word valid.
- `io_in_ready`  out  1  block can accept an operand.
- `io_in`  in  12  ciphertext-side word; nibble i = `io_in[4i+3:4i]`, bit 4i+3 MSB.
- `io_key`  in  12  round-key word, same nibble layout.
- `io_out_valid`  out  1  result word valid.
- `io_out_ready`  in  1  downstream accepts the result.
- `io_out`  out  12  recovered state word.
- `io_fault`  out  1  redundancy-check mismatch for the current result; qualified by `io_out_valid`.

## Operation
- Inverse S-box, input 0..F maps to: 5 E F 8 C 1 2 D B 4 6 3 0 7 9 A.
- Nibble function: `r_i = S⁻¹(io_in_i ^ io_key_i)`.
- FSM states:
  - IDLE: `io_in_ready`=1. On `io_in_valid`, capture `io_in` and `io_key` into internal registers, set idx=0, clear the result register and the fault bit, go to CALC.
  - CALC: compute `r_idx` from the captured registers into a 4-bit temp register. Go to CHECK.
  - CHECK: recompute `r_idx` through the same S-box path and compare with temp.
    - Equal: write temp into result nibble idx. If idx==2, go to DONE; else idx+1, go to CALC.
    - Unequal: set fault, force `io_out` to 12'h000, go to DONE directly. Remaining nibbles are skipped.
- DONE: `io_out_valid`=1, `io_out` and `io_fault` held stable. On `io_out_ready`, zero the captured data and key registers and go to IDLE.
- idx is 2 bits and counts 0..2; the value 3 is unreachable. An illegal state or idx decodes to IDLE with registers cleared.
- `io_in_ready` is asserted only in IDLE. Inputs are ignored in every other state.
- `io_out` is registered. It never shows partial results: its value is exposed only while `io_out_valid`=1 and reads 0 otherwise.

## Timing
- Reset values: `io_in_ready`=1, `io_out_valid`=0, `io_out`=12'h000, `io_fault`=0, FSM in IDLE, idx=0, all data/key/temp registers 0.
- Accept at edge t (IDLE with valid & ready). CALC/CHECK pairs occupy cycles t+1..t+6. `io_out_valid` rises in cycle t+7.
- Fault on nibble idx: DONE is entered one cycle after that nibble's CHECK. The earliest case is `io_out_valid` in cycle t+3.
- With `io_out_ready` held high, DONE lasts 1 cycle. Minimum initiation interval is 8 cycles.
- Backpressure: DONE persists indefinitely with outputs unchanged.
- Simultaneous `io_out_ready` in DONE and `io_in_valid`: no new operand is accepted until the following IDLE cycle, so there is no same-cycle turnaround.
- Reset mid-operation: `io_out_valid` and `io_fault` drop asynchronously, and the in-flight word is discarded. The first accept can occur on the first edge after reset deasserts.

## Test plan
- Round trip: `io_in`=12'hFD7, `io_key`=12'hABC → `io_out`=12'h123, `io_fault`=0, valid rises 7 cycles after accept.
- Exhaustive table: for each v in 0..F, send `io_in`={3{v}}, `io_key`=0 → each nibble equals the inverse table entry; e.g. 12'h000→12'h555, 12'hCCC→12'h000.
- Backpressure: hold `io_out_ready`=0 for 20 cycles in DONE → `io_out` and `io_fault` stable, `io_in_ready`=0, and a pulsed `io_in_valid` is not captured.
- Fault injection: force the temp register of nibble 1 to flip one bit during its CHECK → DONE 5 cycles after accept, `io_out`=12'h000, `io_fault`=1. The next clean word gives `io_fault`=0.
- Reset mid-word: assert `reset`=0 during the second CALC → `io_out_valid`=0 immediately and `io_in_ready`=1 after release. A fresh word completes correctly.
- Back-to-back with `io_out_ready`=1 and continuous valid → one accept every 8 cycles, and every result matches the reference model `S⁻¹(in^key)`.
